// File: rtl/jtag_tap_sampler_if.sv
// jtag_tap_sampler_if: JTAG pin bundle plus the user data register port toward
// the debug logic. master = JTAG driver / debug side, slave = TAP sampler.
interface jtag_tap_sampler_if #(
  parameter int unsigned IR_WIDTH = 5,
  parameter int unsigned DR_WIDTH = 41
);
  logic                jtag_TCK;
  logic                jtag_TMS;
  logic                jtag_TDI;
  logic                jtag_TRSTn;
  logic                jtag_TDO_data;
  logic                jtag_TDO_driven;
  logic                dr_capture_req;
  logic [DR_WIDTH-1:0] dr_capture_data;
  logic                dr_update_valid;
  logic [DR_WIDTH-1:0] dr_update_data;
  logic [IR_WIDTH-1:0] ir_value;

  modport master (
    output jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, dr_capture_data,
    input  jtag_TDO_data, jtag_TDO_driven, dr_capture_req,
           dr_update_valid, dr_update_data, ir_value
  );

  modport slave (
    input  jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, dr_capture_data,
    output jtag_TDO_data, jtag_TDO_driven, dr_capture_req,
           dr_update_valid, dr_update_data, ir_value
  );
endinterface

// File: rtl/jtag_tap_sampler.sv
// jtag_tap_sampler: IEEE 1149.1 TAP controller oversampled on the system clock.
// Provides a 5-bit IR, IDCODE, BYPASS and one user data register with
// capture/update strobes. Optional macro JTAG_TAP_SAMPLER_TRST_EN enables the
// asynchronous-pin TRSTn reset path; without it TRSTn is ignored.
module jtag_tap_sampler #(
  parameter int unsigned         IR_WIDTH     = 5,
  parameter logic [31:0]         IDCODE_VALUE = 32'h0000_0001,
  parameter logic [IR_WIDTH-1:0] USER_IR      = IR_WIDTH'(5'h10),
  parameter int unsigned         DR_WIDTH     = 41
) (
  input  logic              clock,
  input  logic              reset,
  jtag_tap_sampler_if.slave bus
);

  localparam int unsigned         ID_WIDTH  = 32;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(1);

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI,
    ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR, ST_PAUSE_DR, ST_EXIT2_DR, ST_UPD_DR,
    ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
  } tap_state_e;

  tap_state_e state_q, state_d;

  logic tck_s1, tck_s2, tck_q;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic tck_rise, tck_fall;
  logic trst_active;

  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_q;
  logic [ID_WIDTH-1:0] id_shift;
  logic [DR_WIDTH-1:0] user_shift;
  logic                bypass_q;
  logic                cap_req_q;
  logic                upd_valid_q;
  logic [DR_WIDTH-1:0] upd_data_q;
  logic                tdo_q, tdo_drv_q;

  logic sel_idcode, sel_user;
  logic dr_lsb;

  // Two-flop synchronisers on TCK/TMS/TDI, plus a third TCK flop for edge detect
  always_ff @(posedge clock) begin
    if (reset) begin
      tck_s1 <= 1'b0;
      tck_s2 <= 1'b0;
      tck_q  <= 1'b0;
      tms_s1 <= 1'b0;
      tms_s2 <= 1'b0;
      tdi_s1 <= 1'b0;
      tdi_s2 <= 1'b0;
    end else begin
      tck_s1 <= bus.jtag_TCK;
      tck_s2 <= tck_s1;
      tck_q  <= tck_s2;
      tms_s1 <= bus.jtag_TMS;
      tms_s2 <= tms_s1;
      tdi_s1 <= bus.jtag_TDI;
      tdi_s2 <= tdi_s1;
    end
  end

  assign tck_rise = tck_s2 & ~tck_q;
  assign tck_fall = ~tck_s2 & tck_q;

`ifdef JTAG_TAP_SAMPLER_TRST_EN
  logic trst_s1, trst_s2;

  // TRSTn synchroniser, idles deasserted (high)
  always_ff @(posedge clock) begin
    if (reset) begin
      trst_s1 <= 1'b1;
      trst_s2 <= 1'b1;
    end else begin
      trst_s1 <= bus.jtag_TRSTn;
      trst_s2 <= trst_s1;
    end
  end

  assign trst_active = ~trst_s2;
`else
  assign trst_active = 1'b0;
`endif

  // Instruction decode; IDCODE wins if USER_IR is ever set to the same code
  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_user   = (ir_q == USER_IR) && !sel_idcode;
  assign dr_lsb     = sel_idcode ? id_shift[0] : (sel_user ? user_shift[0] : bypass_q);

  // TAP state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_TLR;
    else       state_q <= state_d;
  end

  // TAP next-state: TRST overrides, otherwise advance only on a TCK rise
  always_comb begin
    state_d = state_q;
    if (trst_active) begin
      state_d = ST_TLR;
    end else if (tck_rise) begin
      unique case (state_q)
        ST_TLR:      state_d = tms_s2 ? ST_TLR      : ST_RTI;
        ST_RTI:      state_d = tms_s2 ? ST_SEL_DR   : ST_RTI;
        ST_SEL_DR:   state_d = tms_s2 ? ST_SEL_IR   : ST_CAP_DR;
        ST_CAP_DR:   state_d = tms_s2 ? ST_EXIT1_DR : ST_SHIFT_DR;
        ST_SHIFT_DR: state_d = tms_s2 ? ST_EXIT1_DR : ST_SHIFT_DR;
        ST_EXIT1_DR: state_d = tms_s2 ? ST_UPD_DR   : ST_PAUSE_DR;
        ST_PAUSE_DR: state_d = tms_s2 ? ST_EXIT2_DR : ST_PAUSE_DR;
        ST_EXIT2_DR: state_d = tms_s2 ? ST_UPD_DR   : ST_SHIFT_DR;
        ST_UPD_DR:   state_d = tms_s2 ? ST_SEL_DR   : ST_RTI;
        ST_SEL_IR:   state_d = tms_s2 ? ST_TLR      : ST_CAP_IR;
        ST_CAP_IR:   state_d = tms_s2 ? ST_EXIT1_IR : ST_SHIFT_IR;
        ST_SHIFT_IR: state_d = tms_s2 ? ST_EXIT1_IR : ST_SHIFT_IR;
        ST_EXIT1_IR: state_d = tms_s2 ? ST_UPD_IR   : ST_PAUSE_IR;
        ST_PAUSE_IR: state_d = tms_s2 ? ST_EXIT2_IR : ST_PAUSE_IR;
        ST_EXIT2_IR: state_d = tms_s2 ? ST_UPD_IR   : ST_SHIFT_IR;
        ST_UPD_IR:   state_d = tms_s2 ? ST_SEL_DR   : ST_RTI;
        default:     state_d = ST_TLR;
      endcase
    end
  end

  // Per-state register actions on a TCK rise. The user capture strobe is
  // registered, so the user DR loads dr_capture_data in the cycle the strobe
  // is visible; the next TCK rise is always many clocks away.
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_shift    <= '0;
      ir_q        <= IR_IDCODE;
      id_shift    <= '0;
      user_shift  <= '0;
      bypass_q    <= 1'b0;
      cap_req_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_data_q  <= '0;
    end else begin
      cap_req_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      if (trst_active) begin
        ir_q <= IR_IDCODE;
      end else begin
        if (cap_req_q) user_shift <= bus.dr_capture_data;
        if (tck_rise) begin
          unique case (state_q)
            ST_CAP_IR:   ir_shift <= IR_CAP;
            ST_SHIFT_IR: ir_shift <= {tdi_s2, ir_shift[IR_WIDTH-1:1]};
            ST_UPD_IR:   ir_q     <= ir_shift;
            ST_CAP_DR: begin
              if (sel_idcode)    id_shift  <= IDCODE_VALUE;
              else if (sel_user) cap_req_q <= 1'b1;
              else               bypass_q  <= 1'b0;
            end
            ST_SHIFT_DR: begin
              if (sel_idcode)    id_shift   <= {tdi_s2, id_shift[ID_WIDTH-1:1]};
              else if (sel_user) user_shift <= {tdi_s2, user_shift[DR_WIDTH-1:1]};
              else               bypass_q   <= tdi_s2;
            end
            ST_UPD_DR: begin
              if (sel_user) begin
                upd_valid_q <= 1'b1;
                upd_data_q  <= user_shift;
              end
            end
            default: ;
          endcase
          if (state_d == ST_TLR) ir_q <= IR_IDCODE;
        end
      end
    end
  end

  // TDO launched on the TCK fall; driven only in the two shift states
  always_ff @(posedge clock) begin
    if (reset) begin
      tdo_q     <= 1'b0;
      tdo_drv_q <= 1'b0;
    end else if (trst_active) begin
      tdo_drv_q <= 1'b0;
    end else if (tck_fall) begin
      tdo_drv_q <= (state_q == ST_SHIFT_IR) || (state_q == ST_SHIFT_DR);
      if (state_q == ST_SHIFT_IR)      tdo_q <= ir_shift[0];
      else if (state_q == ST_SHIFT_DR) tdo_q <= dr_lsb;
      else                             tdo_q <= 1'b0;
    end
  end

  assign bus.jtag_TDO_data   = tdo_q;
  assign bus.jtag_TDO_driven = tdo_drv_q;
  assign bus.dr_capture_req  = cap_req_q;
  assign bus.dr_update_valid = upd_valid_q;
  assign bus.dr_update_data  = upd_data_q;
  assign bus.ir_value        = ir_q;

endmodule

// File: tb/tb_jtag_tap_sampler.sv
// tb_jtag_tap_sampler: directed JTAG scans against jtag_tap_sampler with
// hand-computed expectations. Covers JTAG_TAP_SAMPLER_TRST_EN when defined.
module tb_jtag_tap_sampler;

  localparam int unsigned IR_W = 5;
  localparam int unsigned DR_W = 41;
  localparam int unsigned HALF = 8;
  localparam logic [31:0]     IDV   = 32'h1BAD_C0DF;
  localparam logic [4:0]      USER  = 5'h10;
  localparam logic [DR_W-1:0] CAPV  = 41'h1_2345_6789A;
  localparam logic [DR_W-1:0] DATAV = 41'h0A5A5A5A5A5;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  jtag_tap_sampler_if #(.IR_WIDTH(IR_W), .DR_WIDTH(DR_W)) bus ();

  jtag_tap_sampler #(
    .IR_WIDTH(IR_W),
    .IDCODE_VALUE(IDV),
    .USER_IR(USER),
    .DR_WIDTH(DR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cap_cnt = 0;
  int upd_cnt = 0;
  logic [DR_W-1:0] upd_seen = '0;

  // Count strobe pulses, sampled mid-cycle
  always @(negedge clock) begin
    if (bus.dr_capture_req === 1'b1) cap_cnt++;
    if (bus.dr_update_valid === 1'b1) begin
      upd_cnt++;
      upd_seen = bus.dr_update_data;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One TCK period: TDO/driven are sampled just before the rise
  task automatic tck(input logic tms, input logic tdi, output logic tdo, output logic drv);
    bus.jtag_TMS = tms;
    bus.jtag_TDI = tdi;
    wait_clk(1);
    tdo = bus.jtag_TDO_data;
    drv = bus.jtag_TDO_driven;
    bus.jtag_TCK = 1'b1;
    wait_clk(HALF);
    bus.jtag_TCK = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic step(input logic tms);
    logic t, d;
    tck(tms, 1'b0, t, d);
  endtask

  // From Run-Test/Idle: load an IR value, end back in Run-Test/Idle
  task automatic shift_ir(input logic [4:0] val, output logic [4:0] got);
    logic t, d;
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 5; i++) begin
      tck(i == 4, val[i], t, d);
      got[i] = t;
    end
    step(1'b1); step(1'b0);
  endtask

  // From Run-Test/Idle: shift n DR bits, end back in Run-Test/Idle
  task automatic shift_dr(input int n, input logic [63:0] val, output logic [63:0] got,
                          output logic drv_all);
    logic t, d;
    got = '0;
    drv_all = 1'b1;
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, val[i], t, d);
      got[i] = t;
      drv_all = drv_all & d;
    end
    step(1'b1); step(1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.jtag_TCK = 1'b0;
    bus.jtag_TMS = 1'b1;
    bus.jtag_TDI = 1'b0;
    bus.jtag_TRSTn = 1'b1;
    bus.dr_capture_data = '0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);
    checks++; if (bus.ir_value !== 5'h01) begin errors++; $display("FAIL reset_ir: got %h want 01", bus.ir_value); end
    checks++; if (bus.jtag_TDO_data !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b want 0", bus.jtag_TDO_data); end
    checks++; if (bus.jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL reset_drv: got %b want 0", bus.jtag_TDO_driven); end
    checks++; if (bus.dr_capture_req !== 1'b0) begin errors++; $display("FAIL reset_capreq: got %b want 0", bus.dr_capture_req); end
    checks++; if (bus.dr_update_valid !== 1'b0) begin errors++; $display("FAIL reset_updvalid: got %b want 0", bus.dr_update_valid); end
    checks++; if (bus.dr_update_data !== '0) begin errors++; $display("FAIL reset_upddata: got %h want 0", bus.dr_update_data); end
  endtask

  task automatic test_idcode;
    logic [63:0] got;
    logic drv_all;
    int c0;
    c0 = cap_cnt;
    step(1'b0);
    shift_dr(32, 64'h0, got, drv_all);
    checks++; if (got[31:0] !== IDV) begin errors++; $display("FAIL idcode_read: got %h want %h", got[31:0], IDV); end
    checks++; if (drv_all !== 1'b1) begin errors++; $display("FAIL idcode_driven: got %b want 1", drv_all); end
    checks++; if (bus.jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL idcode_idle_drv: got %b want 0", bus.jtag_TDO_driven); end
    checks++; if (cap_cnt - c0 !== 0) begin errors++; $display("FAIL idcode_nocap: got %0d want 0", cap_cnt - c0); end
  endtask

  task automatic test_bypass;
    logic [4:0] gir;
    logic [63:0] got;
    logic drv_all;
    int u0;
    u0 = upd_cnt;
    shift_ir(5'h1F, gir);
    checks++; if (gir !== 5'b00001) begin errors++; $display("FAIL ir_capture: got %b want 00001", gir); end
    checks++; if (bus.ir_value !== 5'h1F) begin errors++; $display("FAIL ir_load_1f: got %h want 1f", bus.ir_value); end
    shift_dr(4, 64'hD, got, drv_all);
    checks++; if (got[3:0] !== 4'b1010) begin errors++; $display("FAIL bypass_delay: got %b want 1010", got[3:0]); end
    checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL bypass_noupd: got %0d want 0", upd_cnt - u0); end
  endtask

  task automatic test_user;
    logic [4:0] gir;
    logic [63:0] got;
    logic drv_all;
    int c0, u0;
    bus.dr_capture_data = CAPV;
    shift_ir(USER, gir);
    checks++; if (bus.ir_value !== USER) begin errors++; $display("FAIL ir_load_user: got %h want %h", bus.ir_value, USER); end
    c0 = cap_cnt;
    u0 = upd_cnt;
    shift_dr(41, {23'd0, DATAV}, got, drv_all);
    checks++; if (got[DR_W-1:0] !== CAPV) begin errors++; $display("FAIL user_tdo: got %h want %h", got[DR_W-1:0], CAPV); end
    checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL user_capreq: got %0d want 1", cap_cnt - c0); end
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL user_updvalid: got %0d want 1", upd_cnt - u0); end
    checks++; if (upd_seen !== DATAV) begin errors++; $display("FAIL user_strobe_data: got %h want %h", upd_seen, DATAV); end
    checks++; if (bus.dr_update_data !== DATAV) begin errors++; $display("FAIL user_held_data: got %h want %h", bus.dr_update_data, DATAV); end
  endtask

  task automatic test_tms_reset;
    logic [4:0] gir;
    logic [63:0] got;
    logic drv_all;
    int u0;
    // BYPASS selected: five TMS=1 edges through Update-DR fire no strobe
    shift_ir(5'h1F, gir);
    u0 = upd_cnt;
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1);
    checks++; if (bus.ir_value !== 5'h01) begin errors++; $display("FAIL tms_reset_ir_a: got %h want 01", bus.ir_value); end
    checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL tms_reset_noupd: got %0d want 0", upd_cnt - u0); end
    step(1'b0);
    // USER selected: Update-DR is traversed once, after one shift of TDI=0
    shift_ir(USER, gir);
    u0 = upd_cnt;
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1);
    checks++; if (bus.ir_value !== 5'h01) begin errors++; $display("FAIL tms_reset_ir_b: got %h want 01", bus.ir_value); end
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL tms_reset_user_upd: got %0d want 1", upd_cnt - u0); end
    checks++; if (upd_seen !== (CAPV >> 1)) begin errors++; $display("FAIL tms_reset_user_data: got %h want %h", upd_seen, CAPV >> 1); end
    step(1'b0);
    shift_dr(32, 64'h0, got, drv_all);
    checks++; if (got[31:0] !== IDV) begin errors++; $display("FAIL tms_reset_idcode: got %h want %h", got[31:0], IDV); end
  endtask

  task automatic test_reset_mid_pause;
    logic [4:0] gir;
    logic [63:0] got;
    logic t, d, drv_all;
    int c0, u0;
    shift_ir(USER, gir);
    step(1'b1); step(1'b0); step(1'b0);
    tck(1'b0, 1'b1, t, d);
    step(1'b1); step(1'b0); step(1'b0);
    c0 = cap_cnt;
    u0 = upd_cnt;
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    checks++; if (bus.ir_value !== 5'h01) begin errors++; $display("FAIL pause_reset_ir: got %h want 01", bus.ir_value); end
    checks++; if (bus.dr_update_data !== '0) begin errors++; $display("FAIL pause_reset_upddata: got %h want 0", bus.dr_update_data); end
    checks++; if (bus.jtag_TDO_driven !== 1'b0 || bus.jtag_TDO_data !== 1'b0) begin errors++; $display("FAIL pause_reset_tdo: got %b%b want 00", bus.jtag_TDO_driven, bus.jtag_TDO_data); end
    step(1'b1); step(1'b1);
    checks++; if (cap_cnt - c0 !== 0 || upd_cnt - u0 !== 0) begin errors++; $display("FAIL pause_reset_nostrobe: got cap %0d upd %0d want 0 0", cap_cnt - c0, upd_cnt - u0); end
    step(1'b0);
    shift_dr(32, 64'h0, got, drv_all);
    checks++; if (got[31:0] !== IDV) begin errors++; $display("FAIL pause_reset_idcode: got %h want %h", got[31:0], IDV); end
  endtask

`ifdef JTAG_TAP_SAMPLER_TRST_EN
  task automatic test_trst;
    logic [63:0] got;
    logic t, d, drv_all;
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    tck(1'b0, 1'b1, t, d);
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL trst_pre_drv: got %b want 1", d); end
    bus.jtag_TRSTn = 1'b0;
    wait_clk(4);
    checks++; if (bus.jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL trst_drv: got %b want 0", bus.jtag_TDO_driven); end
    checks++; if (bus.ir_value !== 5'h01) begin errors++; $display("FAIL trst_ir: got %h want 01", bus.ir_value); end
    step(1'b0); step(1'b0);
    checks++; if (bus.jtag_TDO_driven !== 1'b0) begin errors++; $display("FAIL trst_held_drv: got %b want 0", bus.jtag_TDO_driven); end
    bus.jtag_TRSTn = 1'b1;
    wait_clk(4);
    step(1'b1); step(1'b0);
    shift_dr(32, 64'h0, got, drv_all);
    checks++; if (got[31:0] !== IDV) begin errors++; $display("FAIL trst_idcode: got %h want %h", got[31:0], IDV); end
  endtask
`endif

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_tms_reset();
    test_reset_mid_pause();
`ifdef JTAG_TAP_SAMPLER_TRST_EN
    test_trst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck run still terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
